// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing generator: mode encodings, default
// 640x480@60 timing and width helpers.
`timescale 1ns/1ps
package vga_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_EXT   = 2'd0;
    localparam mode_t MODE_SOLID = 2'd1;
    localparam mode_t MODE_CHECK = 2'd2;
    localparam mode_t MODE_BARS  = 2'd3;

    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int PIX_COORD_W   = 10;
    localparam int PIX_COORD_MAX = 1 << PIX_COORD_W;

    function automatic int rgb_width(input int r_w, input int g_w, input int b_w);
        return r_w + g_w + b_w;
    endfunction

    // Never returns 0 so a degenerate axis still gets a 1-bit counter.
    function automatic int cnt_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical): wrapping counter with active,
// sync-window and last-count decodes. Region order: active, FP, sync, BP.
`timescale 1ns/1ps
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    localparam int TOTAL = ACTIVE + FP + SYNC + BP,
    localparam int CW    = cnt_width(TOTAL)
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          active,
    output logic          sync,
    output logic          last
);

    localparam int SYNC_START = ACTIVE + FP;
    localparam int SYNC_END   = ACTIVE + FP + SYNC;

    logic [CW-1:0] count_reg;
    logic [31:0]   count_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= last ? '0 : count_reg + CW'(1);
        end
    end

    // Decode in 32 bits so a boundary equal to 2**CW cannot alias to zero.
    assign count_ext = 32'(count_reg);
    assign count     = count_reg;
    assign last      = (count_ext == 32'(TOTAL - 1));
    assign active    = (count_ext < 32'(ACTIVE));
    assign sync      = (count_ext >= 32'(SYNC_START)) && (count_ext < 32'(SYNC_END));

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with pixel-request interface, built-in
// test patterns and a two-stage registered output pipeline.
`timescale 1ns/1ps
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int R_W      = 3,
    parameter int G_W      = 3,
    parameter int B_W      = 2,
    parameter int CHK_LOG2 = 5,
    parameter int BAR_LOG2 = 7,
    localparam int RGB_W   = rgb_width(R_W, G_W, B_W)
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             mode,
    input  logic [RGB_W-1:0]       fg_color,
    input  logic [RGB_W-1:0]       pix_data,
    output logic                   pix_req,
    output logic [PIX_COORD_W-1:0] pix_x,
    output logic [PIX_COORD_W-1:0] pix_y,
    output logic                   frame_start,
    output logic [R_W-1:0]         vga_red,
    output logic [G_W-1:0]         vga_green,
    output logic [B_W-1:0]         vga_blue,
    output logic                   h_sync,
    output logic                   v_sync,
    output logic                   de
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HCW     = cnt_width(H_TOTAL);
    localparam int VCW     = cnt_width(V_TOTAL);
    localparam int DIV_W   = cnt_width(CLK_DIV);

    generate
        if (CLK_DIV < 1) begin : g_bad_div
            $error("vga_timing_gen: CLK_DIV must be >= 1");
        end
        if (H_ACTIVE > PIX_COORD_MAX || V_ACTIVE > PIX_COORD_MAX) begin : g_bad_active
            $error("vga_timing_gen: active area exceeds 10-bit pixel coordinates");
        end
        if (CHK_LOG2 > PIX_COORD_W - 1 || BAR_LOG2 + 2 > PIX_COORD_W - 1) begin : g_bad_pattern
            $error("vga_timing_gen: pattern size exceeds pixel coordinate range");
        end
    endgenerate

    // ---------------- stage 0: divider and counters ----------------
    logic [DIV_W-1:0] div_cnt_reg;
    logic             tick;
    logic [HCW-1:0]   h_cnt;
    logic [VCW-1:0]   v_cnt;
    logic             h_active, v_active, h_in_sync, v_in_sync;
    logic             h_last, v_last_unused;
    logic             active;

    // Gated by rst_n so pix_req/frame_start stay low in reset even when CLK_DIV=1.
    assign tick = rst_n && (div_cnt_reg == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= tick ? '0 : div_cnt_reg + DIV_W'(1);
        end
    end

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (tick),
        .count  (h_cnt),
        .active (h_active),
        .sync   (h_in_sync),
        .last   (h_last)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (tick && h_last),
        .count  (v_cnt),
        .active (v_active),
        .sync   (v_in_sync),
        .last   (v_last_unused)
    );

    assign active      = h_active && v_active;
    assign pix_req     = tick && active;
    assign pix_x       = PIX_COORD_W'(h_cnt);
    assign pix_y       = PIX_COORD_W'(v_cnt);
    assign frame_start = tick && (h_cnt == '0) && (v_cnt == '0);

    // ---------------- stage 1: capture ----------------
    logic  s1_tick_reg, s1_active_reg, s1_hs_reg, s1_vs_reg;
    logic  s1_chk_reg;
    logic  [2:0] s1_bar_idx_reg;
    mode_t mode_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_tick_reg    <= 1'b0;
            s1_active_reg  <= 1'b0;
            s1_hs_reg      <= 1'b0;
            s1_vs_reg      <= 1'b0;
            s1_chk_reg     <= 1'b0;
            s1_bar_idx_reg <= 3'd0;
            mode_reg       <= MODE_EXT;
        end else begin
            s1_tick_reg    <= tick;
            s1_active_reg  <= active;
            s1_hs_reg      <= h_in_sync;
            s1_vs_reg      <= v_in_sync;
            s1_chk_reg     <= pix_x[CHK_LOG2] ^ pix_y[CHK_LOG2];
            s1_bar_idx_reg <= pix_x[BAR_LOG2+2:BAR_LOG2];
            // Mode only changes at the frame boundary to avoid tearing.
            if (frame_start) begin
                mode_reg <= mode;
            end
        end
    end

    // ---------------- stage 2: colour select and pins ----------------
    logic [RGB_W-1:0] bar_color;
    logic [RGB_W-1:0] color_next;
    logic [RGB_W-1:0] color_reg;
    logic             de_reg, hs_reg, vs_reg;

    // Each bit of the packed {B,G,R} word follows the bar-index bit of its channel.
    genvar gi;
    generate
        for (gi = 0; gi < RGB_W; gi++) begin : g_bar
            localparam int CH = (gi < R_W) ? 0 : ((gi < R_W + G_W) ? 1 : 2);
            assign bar_color[gi] = s1_bar_idx_reg[CH];
        end
    endgenerate

    always_comb begin
        color_next = '0;
        if (s1_active_reg) begin
            case (mode_reg)
                MODE_EXT:   color_next = pix_data;
                MODE_SOLID: color_next = fg_color;
                MODE_CHECK: color_next = s1_chk_reg ? fg_color : '0;
                MODE_BARS:  color_next = bar_color;
                default:    color_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color_reg <= '0;
            de_reg    <= 1'b0;
            hs_reg    <= ~HS_POL;
            vs_reg    <= ~VS_POL;
        end else if (s1_tick_reg) begin
            color_reg <= color_next;
            de_reg    <= s1_active_reg;
            hs_reg    <= s1_hs_reg ? HS_POL : ~HS_POL;
            vs_reg    <= s1_vs_reg ? VS_POL : ~VS_POL;
        end
    end

    assign vga_red   = color_reg[R_W-1:0];
    assign vga_green = color_reg[R_W +: G_W];
    assign vga_blue  = color_reg[R_W+G_W +: B_W];
    assign h_sync    = hs_reg;
    assign v_sync    = vs_reg;
    assign de        = de_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small-timing instance checked every cycle against
// a cycle-count model, plus a CLK_DIV=1 instance for period and async-reset checks.
`timescale 1ns/1ps
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int D  = 3;
    localparam int HA = 80, HF = 4, HS = 6, HB = 6;
    localparam int VA = 40, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int LINE_CLK  = HT * D;
    localparam int FRAME_CLK = HT * VT * D;
    localparam bit HSP = 1'b0;
    localparam bit VSP = 1'b1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- main DUT ----------------
    logic       rst_n;
    logic [1:0] mode;
    logic [7:0] fg_color, pix_data;
    logic       pix_req, frame_start, h_sync, v_sync, de;
    logic [9:0] pix_x, pix_y;
    logic [2:0] vga_red, vga_green;
    logic [1:0] vga_blue;

    vga_timing_gen #(
        .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(HSP), .VS_POL(VSP), .R_W(3), .G_W(3), .B_W(2),
        .CHK_LOG2(3), .BAR_LOG2(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .fg_color(fg_color), .pix_data(pix_data),
        .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start),
        .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
        .h_sync(h_sync), .v_sync(v_sync), .de(de)
    );

    // Reference colour from the pattern rules (8x8 checker, 16-pixel bars).
    function automatic logic [7:0] model_color(input logic [1:0] m, input int x, input int y,
                                               input logic [7:0] fg, input logic [7:0] pd,
                                               input bit act);
        logic [7:0] c;
        int idx;
        c   = 8'h00;
        idx = (x / 16) % 8;
        if (act) begin
            case (m)
                2'd0: c = pd;
                2'd1: c = fg;
                2'd2: if (((x / 8) + (y / 8)) % 2 == 1) c = fg;
                default: begin
                    if (idx % 2 == 1)       c = c | 8'h07;
                    if ((idx / 2) % 2 == 1) c = c | 8'h38;
                    if (idx / 4 == 1)       c = c | 8'hC0;
                end
            endcase
        end
        return c;
    endfunction

    // Model state (written only by the compare process)
    int         cyc;
    bit         pend, upd, m_req;
    int         m_x, pend_h, pend_v, nxt_x, nxt_y, cur_x, cur_y;
    bit         pend_act, nxt_de, exp_de, cur_new;
    logic [1:0] frame_mode = 2'd0, pend_mode, nxt_mode, cur_mode;
    logic [7:0] nxt_col, exp_col, nxt_fg, cur_fg;
    logic       nxt_hs, nxt_vs, exp_hs, exp_vs;

    initial begin : compare
        int  k, h, v;
        bit  tick, act, fs;
        logic [7:0] rgb;
        m_req = 1'b0;
        forever begin
            @(negedge clk);
            cur_new = 1'b0;
            if (!rst_n) begin
                cyc = 0; pend = 1'b0; upd = 1'b0; m_req = 1'b0;
                exp_col = 8'h00; exp_hs = ~HSP; exp_vs = ~VSP; exp_de = 1'b0;
                chk("rst_pix_req", pix_req, 0);
                chk("rst_frame_start", frame_start, 0);
            end else begin
                tick = (cyc % D) == D - 1;
                k    = cyc / D;
                h    = k % HT;
                v    = (k / HT) % VT;
                act  = (h < HA) && (v < VA);
                fs   = tick && h == 0 && v == 0;
                if (fs) frame_mode = mode;
                if (upd) begin
                    exp_col = nxt_col; exp_hs = nxt_hs; exp_vs = nxt_vs; exp_de = nxt_de;
                    cur_x = nxt_x; cur_y = nxt_y; cur_mode = nxt_mode; cur_fg = nxt_fg;
                    cur_new = 1'b1;
                end
                chk("pix_req", pix_req, tick && act);
                chk("frame_start", frame_start, fs);
                if (tick && act) begin
                    chk("pix_x", pix_x, h);
                    chk("pix_y", pix_y, v);
                end
                m_req = tick && act;
                m_x   = h;
            end
            rgb = {vga_blue, vga_green, vga_red};
            chk("vga_rgb", rgb, exp_col);
            chk("h_sync", h_sync, exp_hs);
            chk("v_sync", v_sync, exp_vs);
            chk("de", de, exp_de);
            // Hand-computed pins at chosen pixels
            if (cur_new && exp_de) begin
                if (cur_mode == 2'd3 && cur_y == 1) begin
                    case (cur_x)
                        0:  chk("bar_x0", rgb, 8'h00);
                        16: chk("bar_x16_red", rgb, 8'h07);
                        32: chk("bar_x32_green", rgb, 8'h38);
                        48: chk("bar_x48_redgreen", rgb, 8'h3F);
                        64: chk("bar_x64_blue", rgb, 8'hC0);
                        default: ;
                    endcase
                end
                if (cur_mode == 2'd2 && cur_x == 8 && cur_y == 0) chk("chk_8_0_fg", rgb, cur_fg);
                if (cur_mode == 2'd2 && cur_x == 8 && cur_y == 8) chk("chk_8_8_zero", rgb, 8'h00);
                if (cur_mode == 2'd1 && cur_x == 8 && cur_y == 8) chk("solid_8_8", rgb, cur_fg);
                if (cur_mode == 2'd0 && cur_x == 5 && cur_y == 3) chk("ext_5_3", rgb, 8'd5);
            end
            if (rst_n) begin
                upd = pend;
                if (pend) begin
                    nxt_col  = model_color(pend_mode, pend_h, pend_v, fg_color, pix_data, pend_act);
                    nxt_hs   = (pend_h >= HA + HF && pend_h < HA + HF + HS) ? HSP : ~HSP;
                    nxt_vs   = (pend_v >= VA + VF && pend_v < VA + VF + VS) ? VSP : ~VSP;
                    nxt_de   = pend_act;
                    nxt_x    = pend_h; nxt_y = pend_v; nxt_mode = pend_mode; nxt_fg = fg_color;
                end
                pend = tick; pend_h = h; pend_v = v; pend_act = act; pend_mode = frame_mode;
                cyc++;
            end
        end
    end

    // Input driver: pix_data answers the previous cycle's request, garbage otherwise.
    initial begin : drive
        pix_data = 8'h00;
        fg_color = 8'h5A;
        forever begin
            @(posedge clk);
            #1;
            pix_data = m_req ? 8'(m_x) : 8'($urandom);
            if ($urandom_range(0, 63) == 0) fg_color = 8'($urandom) | 8'h01;
        end
    end

    // Period and width monitor with literal expectations.
    initial begin : period_mon
        longint t, last_hs, last_vs, last_fs;
        int     reqs;
        logic   prev_hs, prev_vs;
        t = 0; last_hs = -1; last_vs = -1; last_fs = -1; reqs = 0;
        prev_hs = ~HSP; prev_vs = ~VSP;
        forever begin
            @(negedge clk);
            t++;
            if (!rst_n) begin
                last_hs = -1; last_vs = -1; last_fs = -1; reqs = 0;
                prev_hs = ~HSP; prev_vs = ~VSP;
            end else begin
                if (h_sync == HSP && prev_hs != HSP) begin
                    if (last_hs >= 0) chk("hsync_period", t - last_hs, 288);
                    last_hs = t;
                end
                if (h_sync != HSP && prev_hs == HSP && last_hs >= 0) chk("hsync_width", t - last_hs, 18);
                if (v_sync == VSP && prev_vs != VSP) begin
                    if (last_vs >= 0) chk("vsync_period", t - last_vs, 13536);
                    last_vs = t;
                end
                if (v_sync != VSP && prev_vs == VSP && last_vs >= 0) chk("vsync_width", t - last_vs, 576);
                if (frame_start) begin
                    if (last_fs >= 0) begin
                        chk("frame_period", t - last_fs, 13536);
                        chk("req_per_frame", reqs, 3200);
                    end
                    last_fs = t;
                    reqs = 0;
                end
                if (pix_req) reqs++;
                prev_hs = h_sync;
                prev_vs = v_sync;
            end
        end
    end

    // ---------------- small DUT: CLK_DIV=1, 8/1/2/1 x 4/1/1/1 ----------------
    logic       rst2_n;
    logic [1:0] mode2;
    logic [7:0] fg2, pd2;
    logic       pix_req2, frame_start2, h_sync2, v_sync2, de2;
    logic [9:0] pix_x2, pix_y2;
    logic [2:0] red2, green2;
    logic [1:0] blue2;
    bit         done2 = 1'b0;

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .R_W(3), .G_W(3), .B_W(2),
        .CHK_LOG2(2), .BAR_LOG2(1)
    ) dut2 (
        .clk(clk), .rst_n(rst2_n), .mode(mode2), .fg_color(fg2), .pix_data(pd2),
        .pix_req(pix_req2), .pix_x(pix_x2), .pix_y(pix_y2), .frame_start(frame_start2),
        .vga_red(red2), .vga_green(green2), .vga_blue(blue2),
        .h_sync(h_sync2), .v_sync(v_sync2), .de(de2)
    );

    initial begin : small_mon
        longint t, last_hs, last_fs;
        logic   prev_hs;
        t = 0; last_hs = -1; last_fs = -1; prev_hs = 1'b1;
        forever begin
            @(negedge clk);
            t++;
            if (!rst2_n) begin
                last_hs = -1; last_fs = -1; prev_hs = 1'b1;
            end else begin
                if (!h_sync2 && prev_hs) begin
                    if (last_hs >= 0) chk("small_hsync_period", t - last_hs, 12);
                    last_hs = t;
                end
                if (h_sync2 && !prev_hs && last_hs >= 0) chk("small_hsync_width", t - last_hs, 2);
                if (frame_start2) begin
                    if (last_fs >= 0) chk("small_frame_period", t - last_fs, 84);
                    last_fs = t;
                end
                prev_hs = h_sync2;
            end
        end
    end

    initial begin : small_seq
        int n;
        rst2_n = 1'b0; mode2 = 2'd1; fg2 = 8'hA5; pd2 = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst2_n = 1'b1;
        repeat (200) @(posedge clk);
        // find the first cycle of an active run so the next edge keeps de high
        n = 0;
        do begin @(negedge clk); n++; end while (de2 && n < 100);
        do begin @(negedge clk); n++; end while (!de2 && n < 200);
        chk("small_de_seen", de2, 1);
        chk("small_solid", {blue2, green2, red2}, 8'hA5);
        @(posedge clk);
        #2 rst2_n = 1'b0;
        #1;
        chk("async_de2", de2, 0);
        chk("async_rgb2", {blue2, green2, red2}, 0);
        chk("async_hsync2", h_sync2, 1);
        chk("async_vsync2", v_sync2, 1);
        chk("rst_req2", pix_req2, 0);
        chk("rst_fs2", frame_start2, 0);
        repeat (2) @(posedge clk);
        #1 rst2_n = 1'b1;
        @(negedge clk);
        chk("rel_fs2", frame_start2, 1);
        chk("rel_req2", pix_req2, 1);
        chk("rel_x2", pix_x2, 0);
        chk("rel_y2", pix_y2, 0);
        @(negedge clk);
        chk("rel_x2_next", pix_x2, 1);
        chk("rel_fs2_next", frame_start2, 0);
        chk("rel_de2_latency", de2, 0);
        @(negedge clk);
        chk("rel_de2_first", de2, 1);
        chk("rel_rgb2_first", {blue2, green2, red2}, 8'hA5);
        repeat (150) @(posedge clk);
        done2 = 1'b1;
    end

    // ---------------- main sequence ----------------
    initial begin : main_seq
        rst_n = 1'b0;
        mode  = 2'd1;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20 * LINE_CLK + $urandom_range(0, 200)) @(posedge clk);
        #1 mode = 2'd2;
        repeat (FRAME_CLK) @(posedge clk);
        #1 mode = 2'd3;
        repeat (FRAME_CLK) @(posedge clk);
        #1 mode = 2'd0;
        repeat (FRAME_CLK + 5 * LINE_CLK + $urandom_range(0, 100)) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12 * LINE_CLK) @(posedge clk);
        chk("small_sequence_done", done2, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
